cv32e40s_alu_b_cnt_seq: RTL

Multi-cycle sequencer for the Zbb bit-count operations CPOP, CLZ and CTZ. It holds the operand, steps a narrow chunk counter over it CHUNK_W bits per cycle, accumulates the count, and returns a 6-bit result zero-extended to 32 bits. It trades the full 32-bit ripple popcount for a small area-optimised unit in the EX stage. Default timing is data-independent, which 40S requires.

---
 rtl/cv32e40s_pkg.sv | 28 ++
 rtl/cv32e40s_alu_b_cnt_chunk.sv | 25 ++
 rtl/cv32e40s_alu_b_cnt_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types for the Zbb bit-count sequencer.
package cv32e40s_pkg;

  localparam int unsigned BCNT_DATA_W = 32;
  localparam int unsigned BCNT_RES_W  = 6;

  typedef enum logic [1:0] {
    BCNT_CPOP = 2'b00,
    BCNT_CLZ  = 2'b01,
    BCNT_CTZ  = 2'b10
  } bcnt_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } bcnt_state_e;

  // Bit reversal so a trailing-zero count becomes a leading-zero count
  function automatic logic [BCNT_DATA_W-1:0] bcnt_bitrev(input logic [BCNT_DATA_W-1:0] x);
    logic [BCNT_DATA_W-1:0] r;
    for (int i = 0; i < int'(BCNT_DATA_W); i++) begin
      r[i] = x[BCNT_DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/cv32e40s_alu_b_cnt_chunk.sv
// Combinational popcount / leading-zero count / nonzero flag for one chunk.
module cv32e40s_alu_b_cnt_chunk #(
  parameter int unsigned CHUNK_W = 8,
  localparam int unsigned CNT_W  = $clog2(CHUNK_W + 1)
) (
  input  logic [CHUNK_W-1:0] chunk_i,
  output logic [CNT_W-1:0]   popcnt_c,
  output logic [CNT_W-1:0]   lzc_c,
  output logic               nonzero_c
);

  // Count ones; the highest set bit, scanned last, sets the leading-zero count
  always_comb begin
    popcnt_c  = '0;
    lzc_c     = CNT_W'(CHUNK_W);
    nonzero_c = |chunk_i;
    for (int i = 0; i < int'(CHUNK_W); i++) begin
      popcnt_c = popcnt_c + CNT_W'(chunk_i[i]);
      if (chunk_i[i]) begin
        lzc_c = CNT_W'(int'(CHUNK_W) - 1 - i);
      end
    end
  end

endmodule

// File: rtl/cv32e40s_alu_b_cnt_seq.sv
// Multi-cycle CPOP/CLZ/CTZ sequencer, CHUNK_W bits per BUSY cycle.
// Optional feature macro: CV32E40S_BCNT_EARLY_EXIT_EN (CLZ/CTZ leave BUSY at
// the first nonzero chunk). Default build is constant-time.
module cv32e40s_alu_b_cnt_seq
  import cv32e40s_pkg::*;
#(
  parameter int unsigned CHUNK_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] operand_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  localparam int unsigned NCHUNK = BCNT_DATA_W / CHUNK_W;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned CNT_W  = $clog2(CHUNK_W + 1);

  bcnt_state_e             r_state;
  bcnt_state_e             w_next_state;
  logic                    r_lz_mode;
  logic [BCNT_DATA_W-1:0]  r_operand;
  logic [BCNT_RES_W-1:0]   r_acc;
  logic [IDX_W-1:0]        r_idx;
  logic                    r_found;

  bcnt_op_e                w_op;
  logic [CHUNK_W-1:0]      w_chunk;
  logic [CNT_W-1:0]        w_pop;
  logic [CNT_W-1:0]        w_lzc;
  logic                    w_nz;
  logic                    w_last;
  logic                    w_early;

  assign w_op    = bcnt_op_e'(op_i);
  // Operand shifts left each BUSY cycle, so the current chunk is always on top
  assign w_chunk = r_operand[BCNT_DATA_W-1 -: CHUNK_W];
  assign w_last  = (r_idx == IDX_W'(NCHUNK - 1));

`ifdef CV32E40S_BCNT_EARLY_EXIT_EN
  assign w_early = r_lz_mode && w_nz;
`else
  assign w_early = 1'b0;
`endif

  cv32e40s_alu_b_cnt_chunk #(
    .CHUNK_W (CHUNK_W)
  ) u_chunk (
    .chunk_i   (w_chunk),
    .popcnt_c  (w_pop),
    .lzc_c     (w_lzc),
    .nonzero_c (w_nz)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; kill overrides every other request
  always_comb begin
    w_next_state = r_state;
    if (kill_i) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (valid_i)          w_next_state = BUSY;
        BUSY:    if (w_last || w_early) w_next_state = DONE;
        DONE:    if (ready_i)          w_next_state = IDLE;
        default:                       w_next_state = IDLE;
      endcase
    end
  end

  // Outputs decoded from the state register
  always_comb begin
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    result_o = '0;
    case (r_state)
      IDLE: ready_o = 1'b1;
      DONE: begin
        valid_o  = 1'b1;
        result_o = {26'b0, r_acc};
      end
      default: ;
    endcase
  end

  // Datapath: latch on accept, accumulate one chunk per BUSY cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lz_mode <= 1'b0;
      r_operand <= '0;
      r_acc     <= '0;
      r_idx     <= '0;
      r_found   <= 1'b0;
    end else if (kill_i) begin
      r_acc     <= '0;
      r_idx     <= '0;
      r_found   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            r_lz_mode <= (w_op == BCNT_CLZ) || (w_op == BCNT_CTZ);
            r_operand <= (w_op == BCNT_CTZ) ? bcnt_bitrev(operand_i) : operand_i;
            r_acc     <= '0;
            r_idx     <= '0;
            r_found   <= 1'b0;
          end
        end
        BUSY: begin
          r_operand <= r_operand << CHUNK_W;
          r_idx     <= r_idx + IDX_W'(1);
          if (!r_lz_mode) begin
            r_acc <= r_acc + BCNT_RES_W'(w_pop);
          end else if (!r_found) begin
            r_acc   <= r_acc + BCNT_RES_W'(w_lzc);
            r_found <= w_nz;
          end
        end
        default: ;
      endcase
    end
  end

  // The decoder never issues the reserved encoding
  a_no_reserved_op : assert property (
    @(posedge clk) disable iff (!rst_n)
    (valid_i && ready_o && !kill_i) |-> (op_i != 2'b11)
  );

endmodule
